// File: rtl/bits2bytes_stream.sv
// bits2bytes_stream: packs an IN_W-bit valid/ready bit stream little-endian
// into N_BYTES-byte words. Stream bit k lands in byte k/8, bit k%8. A beat
// carrying last flushes a zero-padded partial word.
//
// Optional macro BITS2BYTES_DBUF_EN: adds an output register in front of the
// accumulator so a new word can fill while the previous one drains. Without
// it a FILL/OUT FSM exposes the accumulator directly and stalls input while
// a word is pending.
module bits2bytes_stream #(
    parameter int N_BYTES = 4,
    parameter int IN_W    = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [IN_W-1:0]                bits_i,
    input  logic                           bits_valid_i,
    input  logic                           bits_last_i,
    output logic                           bits_ready_o,
    output logic [N_BYTES-1:0][7:0]        bytes_o,
    output logic [$clog2(N_BYTES+1)-1:0]   bytes_nbytes_o,
    output logic                           bytes_last_o,
    output logic                           bytes_valid_o,
    input  logic                           bytes_ready_i
);

    localparam int W   = N_BYTES * 8;
    localparam int CW  = $clog2(W + 1);
    localparam int IW  = $clog2(W);
    localparam int NBW = $clog2(N_BYTES + 1);

    // Beat width must tile a byte exactly so a word never straddles a beat.
    generate
        if (!(IN_W == 1 || IN_W == 2 || IN_W == 4 || IN_W == 8) || N_BYTES < 1) begin : g_bad_param
            $fatal(1, "bits2bytes_stream: IN_W must be 1, 2, 4 or 8 and N_BYTES >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Accumulator shared by both build variants
    // ------------------------------------------------------------------
    logic [W-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;

    logic [W-1:0]   w_acc_base;
    logic [W-1:0]   w_acc_wr;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_close;
    logic [NBW-1:0] w_nbytes;
    logic           w_accept;

    // Accumulator image after writing the current beat. A word always starts
    // from zero, so every bit above the fill point of a closed word is zero
    // without needing an explicit mask.
    always_comb begin
        w_acc_base = (r_cnt == '0) ? '0 : r_acc;
        w_acc_wr   = w_acc_base;
        w_acc_wr[r_cnt[IW-1:0] +: IN_W] = bits_i;
    end

    assign w_cnt_nxt = r_cnt + CW'(IN_W);
    // Close on a completely filled word or on a message end, whichever first.
    assign w_close   = (w_cnt_nxt == CW'(W)) || bits_last_i;
    // Valid bytes = ceil(bits / 8); W+7 always fits in CW bits.
    assign w_nbytes  = NBW'((w_cnt_nxt + CW'(7)) >> 3);

`ifdef BITS2BYTES_DBUF_EN

    // ------------------------------------------------------------------
    // Double-buffered variant
    // ------------------------------------------------------------------
    logic           r_acc_full;
    logic [NBW-1:0] r_acc_nbytes;
    logic           r_acc_last;
    logic [W-1:0]   r_out;
    logic [NBW-1:0] r_out_nbytes;
    logic           r_out_last;
    logic           r_out_valid;

    logic           w_drain;
    logic           w_out_free;

    assign w_accept   = bits_valid_i && !r_acc_full;
    assign w_drain    = r_out_valid && bytes_ready_i;
    // The output register can take a word if empty or emptying this cycle.
    assign w_out_free = !r_out_valid || w_drain;

    // Accumulator: fill beats; park a closed word only when the output
    // register is still occupied, and release it on the next drain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_acc_full   <= 1'b0;
            r_acc_nbytes <= '0;
            r_acc_last   <= 1'b0;
        end else if (r_acc_full) begin
            if (w_drain) begin
                r_acc_full <= 1'b0;
            end
        end else if (w_accept) begin
            r_acc <= w_acc_wr;
            if (w_close) begin
                r_cnt        <= '0;
                r_acc_nbytes <= w_nbytes;
                r_acc_last   <= bits_last_i;
                r_acc_full   <= !w_out_free;
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    // Output register: load a parked word on drain, otherwise take a
    // closing word straight from the beat when there is room.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out        <= '0;
            r_out_nbytes <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (r_acc_full && w_drain) begin
            r_out        <= r_acc;
            r_out_nbytes <= r_acc_nbytes;
            r_out_last   <= r_acc_last;
            r_out_valid  <= 1'b1;
        end else if (w_accept && w_close && w_out_free) begin
            r_out        <= w_acc_wr;
            r_out_nbytes <= w_nbytes;
            r_out_last   <= bits_last_i;
            r_out_valid  <= 1'b1;
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bits_ready_o   = !r_acc_full;
    assign bytes_valid_o  = r_out_valid;
    assign bytes_o        = r_out;
    assign bytes_nbytes_o = r_out_nbytes;
    assign bytes_last_o   = r_out_last;

`else

    // ------------------------------------------------------------------
    // Base variant: FILL/OUT FSM, output taken straight from accumulator
    // ------------------------------------------------------------------
    typedef enum logic {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NBW-1:0] r_nbytes;
    logic           r_last;

    assign w_accept = bits_valid_i && (r_state == S_FILL);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a closing beat presents the word, a handshake frees it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: if (bits_valid_i && w_close) w_state_nxt = S_OUT;
            S_OUT:  if (bytes_ready_i)           w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Accumulator and word descriptor; frozen while the word is presented.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_nbytes <= '0;
            r_last   <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_wr;
            if (w_close) begin
                r_cnt    <= '0;
                r_nbytes <= w_nbytes;
                r_last   <= bits_last_i;
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign bits_ready_o   = (r_state == S_FILL);
    assign bytes_valid_o  = (r_state == S_OUT);
    assign bytes_o        = r_acc;
    assign bytes_nbytes_o = r_nbytes;
    assign bytes_last_o   = r_last;

`endif

endmodule

// File: tb/tb_bits2bytes_stream.sv
// Directed bench for bits2bytes_stream (N_BYTES=4). Default build uses
// IN_W=1; with BITS2BYTES_DBUF_EN it uses IN_W=8 and runs the throughput
// scenario. A small packing model feeds a scoreboard that is checked on
// every output handshake.
module tb_bits2bytes_stream;

`ifdef BITS2BYTES_DBUF_EN
    localparam int TB_IN_W = 8;
`else
    localparam int TB_IN_W = 1;
`endif

    logic               clk;
    logic               rst;
    logic [TB_IN_W-1:0] bits_i;
    logic               bits_valid_i;
    logic               bits_last_i;
    logic               bits_ready_o;
    logic [3:0][7:0]    bytes_o;
    logic [2:0]         bytes_nbytes_o;
    logic               bytes_last_o;
    logic               bytes_valid_o;
    logic               bytes_ready_i;

    bits2bytes_stream #(.N_BYTES(4), .IN_W(TB_IN_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bits_i         (bits_i),
        .bits_valid_i   (bits_valid_i),
        .bits_last_i    (bits_last_i),
        .bits_ready_o   (bits_ready_o),
        .bytes_o        (bytes_o),
        .bytes_nbytes_o (bytes_nbytes_o),
        .bytes_last_o   (bytes_last_o),
        .bytes_valid_o  (bytes_valid_o),
        .bytes_ready_i  (bytes_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  nb;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_acc;
    int          m_cnt;
    int          n_chk, n_pass, n_fail, n_acc, cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, then look 1 time
    // unit after it and score any word that was taken.
    task automatic tick();
        logic        hs;
        logic [31:0] ob;
        logic [2:0]  onb;
        logic        ol;
        exp_t        e;
        hs  = bytes_valid_o && bytes_ready_i;
        ob  = bytes_o;
        onb = bytes_nbytes_o;
        ol  = bytes_last_o;
        if (bits_valid_i && bits_ready_o) n_acc++;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            if (sb.size() == 0) begin
                check("unexpected_word_nbytes", onb, 0);
            end else begin
                e = sb.pop_front();
                check("sb_data", ob, e.data);
                check("sb_nbytes", onb, e.nb);
                check("sb_last", ol, e.last);
            end
        end
    endtask

    // Present one beat until accepted; the model records the packed word.
    task automatic send_beat(input logic [7:0] b, input logic lst);
        int   guard;
        exp_t e;
        guard        = 0;
        bits_valid_i = 1'b1;
        bits_i       = b[TB_IN_W-1:0];
        bits_last_i  = lst;
        while (!bits_ready_o && guard < 200) begin
            tick();
            guard++;
        end
        if (!bits_ready_o) check("ready_timeout", bits_ready_o, 1);
        for (int k = 0; k < TB_IN_W; k++) m_acc[m_cnt + k] = b[k];
        m_cnt += TB_IN_W;
        if (m_cnt == 32 || lst) begin
            e.data = m_acc;
            e.nb   = 3'((m_cnt + 7) / 8);
            e.last = lst;
            sb.push_back(e);
            m_acc = '0;
            m_cnt = 0;
        end
        tick();
        bits_valid_i = 1'b0;
        bits_last_i  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int nbits, input logic lst);
        for (int i = 0; i < nbits; i += TB_IN_W)
            send_beat(8'(v >> i), lst && (i + TB_IN_W >= nbits));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcyc[$];
        n_chk = 0; n_pass = 0; n_fail = 0; n_acc = 0; cyc = 0;
        m_acc = '0; m_cnt = 0;
        rst = 1'b1; bits_i = '0; bits_valid_i = 1'b0; bits_last_i = 1'b0;
        bytes_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_bytes", bytes_o, 0);
        check("rst_nbytes", bytes_nbytes_o, 0);
        check("rst_last", bytes_last_o, 0);
        check("rst_valid", bytes_valid_o, 0);
        rst = 1'b0;
        #1;
        check("rst_ready", bits_ready_o, 1);
        bytes_ready_i = 1'b1;

`ifdef BITS2BYTES_DBUF_EN
        // Back-to-back bytes, consumer always ready: no idle cycle.
        for (int i = 0; i < 8; i++) begin
            send_beat(8'(i), 1'b0);
            check("dbuf_ready", bits_ready_o, 1);
            if (bytes_valid_o) begin
                vcyc.push_back(cyc);
                check("dbuf_word", bytes_o, (i == 3) ? 32'h03020100 : 32'h07060504);
            end
        end
        check("dbuf_nwords", vcyc.size(), 2);
        if (vcyc.size() == 2) check("dbuf_spacing", vcyc[1] - vcyc[0], 4);
        tick();
        check("dbuf_drained", bytes_valid_o, 0);

        // Partial flush on byte beats
        send_word(32'h0A5F, 16, 1'b1);
        check("dbuf_part_data", bytes_o, 32'h00000A5F);
        check("dbuf_part_nb", bytes_nbytes_o, 2);
        check("dbuf_part_last", bytes_last_o, 1);
        tick();

        // Reset mid-word clears both registers
        send_word(32'h00FFFF, 16, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("dbuf_mrst_bytes", bytes_o, 0);
        check("dbuf_mrst_valid", bytes_valid_o, 0);
        #3 rst = 1'b0;
        m_acc = '0; m_cnt = 0;
        @(posedge clk);
        #1;
        send_word(32'h00000001, 32, 1'b0);
        check("dbuf_post_rst", bytes_o, 32'h00000001);
        tick();
`else
        // Full word, valid exactly one cycle after bit 31
        send_word(32'h89ABCDEF, 31, 1'b0);
        check("full_not_early", bytes_valid_o, 0);
        send_beat(8'h01, 1'b0);
        check("full_valid", bytes_valid_o, 1);
        check("full_data", bytes_o, 32'h89ABCDEF);
        check("full_nb", bytes_nbytes_o, 4);
        check("full_last", bytes_last_o, 0);
        check("full_ready_low", bits_ready_o, 0);
        tick();
        check("full_ready_back", bits_ready_o, 1);
        check("full_valid_gone", bytes_valid_o, 0);

        // Partial flush: 12 bits with last
        send_word(32'h00000A5F, 12, 1'b1);
        check("part_data", bytes_o, 32'h00000A5F);
        check("part_nb", bytes_nbytes_o, 2);
        check("part_last", bytes_last_o, 1);
        tick();

        // Backpressure: 10 stalled cycles, beat offered but not taken
        bytes_ready_i = 1'b0;
        send_word(32'h12345678, 32, 1'b0);
        begin
            int a0;
            a0 = n_acc;
            bits_valid_i = 1'b1;
            bits_i = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                check("bp_valid", bytes_valid_o, 1);
                check("bp_data", bytes_o, 32'h12345678);
                check("bp_ready", bits_ready_o, 0);
            end
            check("bp_no_accept", n_acc, a0);
        end
        bits_valid_i = 1'b0;
        bytes_ready_i = 1'b1;
        tick();
        check("bp_drained", bytes_valid_o, 0);
        check("bp_sb_empty", sb.size(), 0);

        // Full word that also carries last, then a fresh word from cnt=0
        send_word(32'hFFFFFFFF, 32, 1'b1);
        check("fl_data", bytes_o, 32'hFFFFFFFF);
        check("fl_nb", bytes_nbytes_o, 4);
        check("fl_last", bytes_last_o, 1);
        tick();
        send_word(32'h0000003C, 8, 1'b1);
        check("fl_next_data", bytes_o, 32'h0000003C);
        check("fl_next_nb", bytes_nbytes_o, 1);
        tick();

        // Asynchronous reset after 17 bits
        send_word(32'h0001FFFF, 17, 1'b0);
        check("mrst_waiting", bytes_valid_o, 0);
        #2 rst = 1'b1;
        #1;
        check("mrst_bytes", bytes_o, 0);
        check("mrst_nbytes", bytes_nbytes_o, 0);
        check("mrst_last", bytes_last_o, 0);
        check("mrst_valid", bytes_valid_o, 0);
        #3 rst = 1'b0;
        m_acc = '0; m_cnt = 0;
        @(posedge clk);
        #1;
        check("mrst_ready", bits_ready_o, 1);
        send_word(32'h00000001, 32, 1'b0);
        check("mrst_post_data", bytes_o, 32'h00000001);
        check("mrst_post_nb", bytes_nbytes_o, 4);
        tick();
`endif

        check("sb_final_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bits2bytes_stream.md
# bits2bytes_stream

Streaming bit-to-byte packer implementing the BitsToBytes direction of the conversion library (inverse of `bytes2bits`). It accepts a bit stream over a valid/ready handshake in `IN_W`-bit beats and packs it little-endian into `N_BYTES`-byte words. Stream bit k lands in byte k/8, bit k mod 8. A `last` marker flushes a zero-padded partial word, so the block sits between serial/bit-level producers (samplers, decoders) and byte-oriented consumers (hash/encode stages).

## Interface
- `N_BYTES`, 4: bytes per output word; ≥1.
- `IN_W`, 1: bits per input beat; must be 1, 2, 4 or 8 (elaboration `$fatal` otherwise).
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: reset; asynchronous, active-high.
- `bits_i` input `IN_W`: input beat; `bits_i[0]` is the earliest stream bit.
- `bits_valid_i` input 1: beat valid.
- `bits_last_i` input 1: beat is the final beat of a message; qualified by valid.
- `bits_ready_o` output 1: block accepts a beat this cycle.
- `bytes_o` output `[N_BYTES-1:0][7:0]`: packed word; byte 0 holds stream bits 0..7.
- `bytes_nbytes_o` output `$clog2(N_BYTES+1)`: number of valid bytes in `bytes_o` (1..N_BYTES).
- `bytes_last_o` output 1: word closes a message.
- `bytes_valid_o` output 1: word valid.
- `bytes_ready_i` input 1: consumer accepts word.

## Operation
- Accumulator `acc` (N_BYTES*8 bits) and bit counter `cnt` (0..N_BYTES*8, steps of `IN_W`). An accepted beat writes `acc[cnt +: IN_W] = bits_i` and sets `cnt += IN_W`.
- Word closes on the accepted beat where `cnt+IN_W == N_BYTES*8`, or where `bits_last_i=1`.
- On close:
  - Bits at or above the new `cnt` are zero.
  - `nbytes = ceil(new_cnt/8)`.
  - `last = bits_last_i`.
  - `cnt` returns to 0.
  - A beat that both fills the word and carries last gives `nbytes=N_BYTES`, `last=1`.
- Base FSM (macro undefined):
  - FILL: `bits_ready_o=1`, `bytes_valid_o=0`.
  - A closing beat moves the FSM to OUT.
  - OUT: `bits_ready_o=0`, `bytes_valid_o=1`, outputs stable.
  - OUT moves to FILL on `bytes_valid_o && bytes_ready_i`.
- Output held stable while `bytes_valid_o=1` and `bytes_ready_i=0`; never retracted.
- `bits_valid_i=0` in FILL holds all state; a partial word waits indefinitely.
- No empty words: a word is emitted only after at least one accepted beat.
- Reset, including mid-word or mid-OUT:
  - The partial word is discarded; `cnt=0`, state FILL.
  - All outputs are 0: `bytes_o=0`, `bytes_nbytes_o=0`, `bytes_last_o=0`, `bytes_valid_o=0`.
  - `bits_ready_o` is 1 once reset deasserts.

## Timing
- `bytes_valid_o` rises the cycle after the closing beat is accepted (latency 1).
- Base mode throughput: one full word per N_BYTES*8/IN_W + 1 cycles with `bytes_ready_i` held high.
- `bits_ready_o` and `bytes_valid_o` are driven from registers only; there is no combinational path from inputs to handshake outputs.

## Configuration
- `BITS2BYTES_DBUF_EN` defined: adds an output register separate from the accumulator.
  - A closed word transfers to the output register at the closing edge if that register is empty, or is drained in the same cycle.
  - Otherwise the word stays in the accumulator with a `acc_full` flag set.
  - `bits_ready_o = !acc_full` (registered).
  - `acc_full` clears, and the word transfers, on the next output handshake.
  - Result: full throughput of one word per N_BYTES*8/IN_W cycles, with no idle cycle.
  - Latency is still 1 cycle.
  - Reset clears both registers.
- `BITS2BYTES_DBUF_EN` undefined: base FILL/OUT FSM as described in Operation.

## Test plan
(All scenarios use N_BYTES=4, IN_W=1 unless noted.)
- Full word: 32 bits of 0x89ABCDEF, LSB first, one per cycle, consumer ready.
  - Required: `bytes_o[0..3]=EF,CD,AB,89`, `nbytes=4`, `last=0`, valid one cycle after bit 31.
  - Base mode: `bits_ready_o=0` for exactly 1 cycle.
- Partial flush: 12 bits of 0xA5F, last on bit 11.
  - Required: `bytes_o[0..3]=5F,0A,00,00`, `nbytes=2`, `last=1`.
- Backpressure: hold `bytes_ready_i=0` for 10 cycles after a word closes.
  - Required: outputs stable throughout, no beats accepted (base mode), and the word drains on the cycle ready rises.
- Full+last: 32 ones with last on bit 31.
  - Required: `bytes_o=FFFFFFFF`, `nbytes=4`, `last=1`.
  - Next word starts at `cnt=0`.
- Reset mid-word: assert `rst_i` asynchronously after 17 bits.
  - Required: all outputs 0 immediately.
  - Then feed 0x00000001: the result is `bytes_o[0]=01`, with no residue from the earlier bits.
- DBUF throughput (macro defined, IN_W=8): 8 beats of 0x00..0x07 back to back, consumer always ready.
  - Required: two words, `03020100` then `07060504`, valid on consecutive 4-cycle boundaries.
  - `bits_ready_o` stays 1 throughout.
